// File: rtl/decoder_2_4_hold_if.sv
// Request/strobe bundle between the upstream encoder side (master) and decoder_2_4_hold (slave).
// DEC_STICKY_EN adds the sticky-line clear input and the sticky observation output.
interface decoder_2_4_hold_if;
  logic       EIN;
  logic [1:0] in;
  logic       ready;
  logic [3:0] out;
  logic       EOUT;
  logic       done;
`ifdef DEC_STICKY_EN
  logic       clr_sticky;
  logic [3:0] sticky;

  modport master (
    output EIN, in, clr_sticky,
    input  ready, out, EOUT, done, sticky
  );

  modport slave (
    input  EIN, in, clr_sticky,
    output ready, out, EOUT, done, sticky
  );
`else
  modport master (
    output EIN, in,
    input  ready, out, EOUT, done
  );

  modport slave (
    input  EIN, in,
    output ready, out, EOUT, done
  );
`endif
endinterface

// File: rtl/decoder_2_4_hold.sv
// Registered 2-to-4 decoder that holds each accepted one-hot line for HOLD cycles.
// Optional feature macro: DEC_STICKY_EN (sticky record of every line decoded since clear/reset).
module decoder_2_4_hold #(
  parameter int HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  decoder_2_4_hold_if.slave bus
);

  generate
    if ((HOLD < 1) || (HOLD > 255)) begin : g_bad_hold
      $error("decoder_2_4_hold: HOLD must be in 1..255");
    end
  endgenerate

  localparam logic [7:0] HOLD_M1     = 8'(HOLD - 1);
  localparam bit         SINGLE_HOLD = (HOLD == 1);

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       accept;
  logic [3:0] line;

  // ready is a registered flag, so acceptance never depends combinationally on EIN via ready.
  assign accept = bus.EIN & bus.ready;
  assign line   = 4'b0001 << bus.in;

  // NOTE: synchronous reset lives inside the clocked block and all state uses non-blocking
  // assignments so every register samples the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bus.out   <= '0;
      bus.EOUT  <= 1'b0;
      bus.ready <= 1'b1;
      bus.done  <= 1'b0;
    end else if (accept) begin
      // Accept is only possible when idle or in the final hold cycle, so this covers back-to-back.
      state     <= ST_HOLD;
      cnt       <= HOLD_M1;
      bus.out   <= line;
      bus.EOUT  <= 1'b1;
      bus.ready <= SINGLE_HOLD;
      bus.done  <= SINGLE_HOLD;
    end else if (state == ST_HOLD) begin
      if (cnt != 8'd0) begin
        cnt       <= cnt - 8'd1;
        bus.ready <= (cnt == 8'd1);
        bus.done  <= (cnt == 8'd1);
      end else begin
        state     <= ST_IDLE;
        bus.out   <= '0;
        bus.EOUT  <= 1'b0;
        bus.ready <= 1'b1;
        bus.done  <= 1'b0;
      end
    end
  end

`ifdef DEC_STICKY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.sticky <= '0;
    end else if (bus.clr_sticky) begin
      bus.sticky <= accept ? line : 4'b0000;
    end else if (accept) begin
      bus.sticky <= bus.sticky | line;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_2_4_hold.sv
// Self-checking bench: HOLD=4 and HOLD=1 decoders driven in parallel against a line/lifetime model.
// Directed scenarios first, then randomized traffic with occasional resets.
module tb_decoder_2_4_hold;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ein;
  logic [1:0] din;
  logic       clr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decoder_2_4_hold_if b4 ();
  decoder_2_4_hold_if b1 ();

  assign b4.EIN = ein;
  assign b4.in  = din;
  assign b1.EIN = ein;
  assign b1.in  = din;
`ifdef DEC_STICKY_EN
  assign b4.clr_sticky = clr;
  assign b1.clr_sticky = clr;
`endif

  decoder_2_4_hold #(.HOLD(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  decoder_2_4_hold #(.HOLD(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  // Model: which index is on the wire (-1 = nothing) and how many asserted cycles remain.
  int         hold_v [2] = '{4, 1};
  int         m_line [2];
  int         m_left [2];
  logic [3:0] m_sticky [2];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready(input int d);
    return (m_line[d] < 0) || (m_left[d] == 1);
  endfunction

  function automatic logic [3:0] m_out(input int d);
    return (m_line[d] < 0) ? 4'b0000 : 4'(1 << m_line[d]);
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit acc;
      acc = ein && m_ready(d);
      if (!rst_n) begin
        m_line[d]   = -1;
        m_left[d]   = 0;
        m_sticky[d] = 4'b0000;
      end else begin
        if (clr) m_sticky[d] = acc ? 4'(1 << din) : 4'b0000;
        else if (acc) m_sticky[d] = m_sticky[d] | 4'(1 << din);
        if (acc) begin
          m_line[d] = int'(din);
          m_left[d] = hold_v[d];
        end else if (m_line[d] >= 0) begin
          m_left[d]--;
          if (m_left[d] == 0) m_line[d] = -1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("h4.out",   {4'b0, b4.out},   {4'b0, m_out(0)});
    check("h4.EOUT",  {7'b0, b4.EOUT},  {7'b0, m_line[0] >= 0});
    check("h4.ready", {7'b0, b4.ready}, {7'b0, m_ready(0)});
    check("h4.done",  {7'b0, b4.done},  {7'b0, (m_line[0] >= 0) && (m_left[0] == 1)});
    check("h1.out",   {4'b0, b1.out},   {4'b0, m_out(1)});
    check("h1.EOUT",  {7'b0, b1.EOUT},  {7'b0, m_line[1] >= 0});
    check("h1.ready", {7'b0, b1.ready}, {7'b0, m_ready(1)});
    check("h1.done",  {7'b0, b1.done},  {7'b0, (m_line[1] >= 0) && (m_left[1] == 1)});
`ifdef DEC_STICKY_EN
    check("h4.sticky", {4'b0, b4.sticky}, {4'b0, m_sticky[0]});
    check("h1.sticky", {4'b0, b1.sticky}, {4'b0, m_sticky[1]});
`endif
  endtask

  // Inputs change at the falling edge; the model advances on the rising edge; outputs are
  // compared at the following falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_steps(input int n);
    ein = 1'b0;
    din = 2'bx;
    clr = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    m_line   = '{-1, -1};
    m_left   = '{0, 0};
    m_sticky = '{4'b0, 4'b0};
    rst_n = 1'b0;
    ein   = 1'b0;
    din   = 2'bx;
    clr   = 1'b0;

    // Reset then idle, with in=X while EIN=0.
    step();
    step();
    check("rst.out",   {4'b0, b4.out},   8'h00);
    check("rst.ready", {7'b0, b4.ready}, 8'h01);
    check("rst.done",  {7'b0, b4.done},  8'h00);
    rst_n = 1'b1;
    idle_steps(3);
    check("idle.EOUT", {7'b0, b4.EOUT}, 8'h00);

    // Single decode of index 2: four asserted cycles, done and ready only on the last.
    ein = 1'b1;
    din = 2'd2;
    step();
    ein = 1'b0;
    din = 2'bx;
    for (int i = 0; i < 4; i++) begin
      check("single.out",   {4'b0, b4.out},   8'h04);
      check("single.done",  {7'b0, b4.done},  {7'b0, i == 3});
      check("single.ready", {7'b0, b4.ready}, {7'b0, i == 3});
      step();
    end
    check("single.after", {4'b0, b4.out}, 8'h00);
    idle_steps(2);

    // Back-to-back: index 0 then index 3 presented at the done cycle, no zero gap.
    ein = 1'b1;
    din = 2'd0;
    for (int c = 0; c < 8; c++) begin
      step();
      check("b2b.out", {4'b0, b4.out}, (c < 4) ? 8'h01 : 8'h08);
      if (c == 3) din = 2'd3;
      if (c == 7) begin
        ein = 1'b0;
        din = 2'bx;
      end
    end
    idle_steps(2);

    // Blocked request: index changes to 1 while busy and is taken only once ready.
    ein = 1'b1;
    din = 2'd2;
    step();
    din = 2'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("blocked.hold", {4'b0, b4.out}, 8'h04);
    end
    step();
    check("blocked.take", {4'b0, b4.out}, 8'h02);
    idle_steps(5);

    // HOLD=1: one index per cycle appears on consecutive cycles.
    ein = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 2'(i);
      step();
      check("hold1.seq", {4'b0, b1.out}, 8'(1 << i));
    end
    idle_steps(5);

    // Reset during the second hold cycle of index 1 aborts without a done pulse.
    ein = 1'b1;
    din = 2'd1;
    step();
    ein = 1'b0;
    din = 2'bx;
    step();
    rst_n = 1'b0;
    step();
    check("abort.out",   {4'b0, b4.out},   8'h00);
    check("abort.EOUT",  {7'b0, b4.EOUT},  8'h00);
    check("abort.ready", {7'b0, b4.ready}, 8'h01);
    check("abort.done",  {7'b0, b4.done},  8'h00);
    rst_n = 1'b1;
    idle_steps(2);

`ifdef DEC_STICKY_EN
    ein = 1'b1;
    din = 2'd0;
    step();
    idle_steps(4);
    ein = 1'b1;
    din = 2'd2;
    step();
    check("sticky.or", {4'b0, b4.sticky}, 8'h05);
    idle_steps(4);
    ein = 1'b1;
    din = 2'd3;
    clr = 1'b1;
    step();
    check("sticky.clr_acc", {4'b0, b4.sticky}, 8'h08);
    idle_steps(5);
`endif

    // Randomized traffic with occasional resets and sticky clears.
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      ein   = ($urandom_range(0, 3) != 0);
      din   = ein ? 2'($urandom_range(0, 3)) : 2'bx;
      clr   = ($urandom_range(0, 7) == 0);
      step();
    end
    idle_steps(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
